pipe_cond_unit: RTL and testbench
=================================

Name: pipe_cond_unit

Overview:
- Execute-stage conditional-execution unit of the pipelined ARM-subset core.
- Sits directly downstream of the ALU decoder and consumes its FlagW and NoWrite outputs after they pass through the ID/EX register.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition against the stored flags.
- Gates RegWrite, MemWrite and PCSrc for the instruction in EX, and commits new ALU flags under FlagW control.

Parameters:
- FLAG_RST, 4'b0000: NZCV value loaded on reset, ordered {N,Z,C,V}.
- NV_ALWAYS, 0: if 1, cond 4'b1111 executes; if 0, it never executes and raises illegal_cond_e.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_e  in  1  EX holds a real instruction; 0 means bubble.
- stall_e  in  1  EX is held this cycle; the same instruction repeats next cycle.
- cond_e  in  4  instruction condition field, Instr[31:28].
- flag_w_e  in  2  decoder FlagW; [1] enables N,Z write, [0] enables C,V write.
- no_write_e  in  1  decoder NoWrite (CMP-class); suppresses the register write.
- reg_write_e  in  1  ungated register-write control.
- mem_write_e  in  1  ungated memory-write control.
- pc_src_e  in  1  ungated PC redirect (branch, or write to R15).
- alu_flags_e  in  4  ALU result flags {N,Z,C,V} for the instruction in EX.
- cond_ex_e  out  1  condition passed and valid_e is 1.
- reg_write_g  out  1  reg_write_e & cond_ex_e & ~no_write_e.
- mem_write_g  out  1  mem_write_e & cond_ex_e.
- pc_src_g  out  1  pc_src_e & cond_ex_e; this is the branch-taken / flush request to IF/ID.
- flags_q  out  4  current architectural NZCV.
- illegal_cond_e  out  1  valid_e & (cond_e==4'b1111) & ~NV_ALWAYS.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - flags_q takes FLAG_RST immediately.
  - All gated outputs follow their combinational equations; with valid_e=0 they are 0.
- Condition evaluation:
  - Combinational, uses flags_q only, never alu_flags_e. Zero-cycle latency.
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; NV per NV_ALWAYS.
- Flag commit, at the rising edge when valid_e & ~stall_e & cond_ex_e:
  - if flag_w_e[1], N,Z take alu_flags_e[3:2];
  - if flag_w_e[0], C,V take alu_flags_e[1:0];
  - otherwise the flags hold.
- Commit latency: new flags are visible on flags_q one cycle after the setting instruction's EX cycle. A back-to-back dependent conditional instruction therefore reads correct flags and needs no bypass.
- stall_e=1: flags hold regardless of flag_w_e. Gated outputs still evaluate, and the downstream EX/MEM register is responsible for ignoring them.
- valid_e=0 (bubble or flushed slot): cond_ex_e=0, all gated outputs 0, no flag write, illegal_cond_e=0.
- A failed condition blocks all side effects, including the flag write. A CMP with failed condition leaves NZCV unchanged.
- CMP (no_write_e=1, flag_w_e=2'b11, passing): flags update and reg_write_g=0.
- flag_w_e=2'b01 is not generated by the decoder. If it arrives, it still writes C,V only; the bench checks this.
- Reset asserted mid-stream: flags return to FLAG_RST asynchronously. On the first edge after rst_n rises, a commit occurs only if its conditions hold that cycle.
- No X-propagation: the unit computes deterministic outputs even if cond_e or flags are X-free but arbitrary.

Decomposition:
- Shared package pipe_pkg:
  - cond_t enum of the 16 condition encodings;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - flagw_t for the 2-bit FlagW field.
- One natural sub-module, pipe_cond_check: purely combinational (cond_t, flags) -> pass. It is instantiated once here and is reusable by a later branch-predict-verify stage.
- The flag register and gating stay in pipe_cond_unit.

Test Plan:
- Reset: rst_n=0 with FLAG_RST=4'b0000 -> flags_q=0000. Then cond_e=EQ, valid_e=1, reg_write_e=1 -> cond_ex_e=0, reg_write_g=0.
- SUBS then BEQ: cycle 0 has flag_w_e=11, cond=AL, alu_flags_e=0100 -> flags_q=0100 at cycle 1. Cycle 1 has cond=EQ, pc_src_e=1 -> pc_src_g=1.
- CMP NE-failed: flags_q=0100, cond=NE, flag_w_e=11, no_write_e=1, alu_flags_e=1000 -> cond_ex_e=0 and flags_q stays 0100.
- Logical-op partial update: flags_q=0011, flag_w_e=10, alu_flags_e=1000 -> flags_q=1011; C,V preserved.
- Stall/bubble: stall_e=1 with flag_w_e=11, alu_flags_e=1111 -> flags_q unchanged. Then valid_e=0 with mem_write_e=1 -> mem_write_g=0.
- Full condition sweep: all 16 conds x 16 NZCV values vs reference truth table. With NV_ALWAYS=0, cond=1111 -> illegal_cond_e=1, cond_ex_e=0. Also assert rst_n mid-sweep -> immediate flags_q=FLAG_RST.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the execute-stage conditional-execution logic.
package pipe_pkg;

  // ARM condition field encodings, Instr[31:28]
  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_t;

  // Bit positions within the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Decoder FlagW field: [1] writes N,Z and [0] writes C,V
  typedef enum logic [1:0] {
    FlagWNone = 2'b00,
    FlagWCv   = 2'b01,
    FlagWNz   = 2'b10,
    FlagWAll  = 2'b11
  } flagw_t;

endpackage

// File: rtl/pipe_cond_unit_if.sv
// EX-stage control bundle seen by the conditional-execution unit.
interface pipe_cond_unit_if;
  logic       valid_e;
  logic       stall_e;
  logic [3:0] cond_e;
  logic [1:0] flag_w_e;
  logic       no_write_e;
  logic       reg_write_e;
  logic       mem_write_e;
  logic       pc_src_e;
  logic [3:0] alu_flags_e;
  logic       cond_ex_e;
  logic       reg_write_g;
  logic       mem_write_g;
  logic       pc_src_g;
  logic [3:0] flags_q;
  logic       illegal_cond_e;

  // Pipeline side: drives the ungated controls, receives the gated ones
  modport master (
    output valid_e, stall_e, cond_e, flag_w_e, no_write_e,
    output reg_write_e, mem_write_e, pc_src_e, alu_flags_e,
    input  cond_ex_e, reg_write_g, mem_write_g, pc_src_g, flags_q, illegal_cond_e
  );

  // Conditional-execution unit side
  modport slave (
    input  valid_e, stall_e, cond_e, flag_w_e, no_write_e,
    input  reg_write_e, mem_write_e, pc_src_e, alu_flags_e,
    output cond_ex_e, reg_write_g, mem_write_g, pc_src_g, flags_q, illegal_cond_e
  );
endinterface

// File: rtl/pipe_cond_check.sv
// Purely combinational condition evaluator: (cond, NZCV) -> pass.
module pipe_cond_check
  import pipe_pkg::*;
#(
  parameter bit NV_ALWAYS = 1'b0
) (
  input  cond_t      cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // Decode the condition against the supplied flags
  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      CondEq: pass_o = z;
      CondNe: pass_o = ~z;
      CondCs: pass_o = c;
      CondCc: pass_o = ~c;
      CondMi: pass_o = n;
      CondPl: pass_o = ~n;
      CondVs: pass_o = v;
      CondVc: pass_o = ~v;
      CondHi: pass_o = c & ~z;
      CondLs: pass_o = ~c | z;
      CondGe: pass_o = (n == v);
      CondLt: pass_o = (n != v);
      CondGt: pass_o = ~z & (n == v);
      CondLe: pass_o = z | (n != v);
      CondAl: pass_o = 1'b1;
      CondNv: pass_o = NV_ALWAYS;
    endcase
  end

endmodule

// File: rtl/pipe_cond_unit.sv
// Execute-stage conditional execution: holds NZCV, gates side effects of the EX instruction.
module pipe_cond_unit
  import pipe_pkg::*;
#(
  parameter logic [3:0] FLAG_RST  = 4'b0000,
  parameter bit         NV_ALWAYS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_cond_unit_if.slave  bus_io
);

  logic [3:0] flags_q, flags_d;
  logic       pass;
  logic       cond_ex;
  logic       commit;

  // Evaluation uses only the stored flags; the ALU flags of the same
  // instruction never feed back into its own condition.
  pipe_cond_check #(
    .NV_ALWAYS (NV_ALWAYS)
  ) u_cond_check (
    .cond_i  (cond_t'(bus_io.cond_e)),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  assign cond_ex = bus_io.valid_e & pass;
  assign commit  = bus_io.valid_e & ~bus_io.stall_e & cond_ex;

  // Next flags: N,Z and C,V pairs are written independently
  always_comb begin
    flags_d = flags_q;
    if (commit && bus_io.flag_w_e[1]) begin
      flags_d[FLAG_N] = bus_io.alu_flags_e[FLAG_N];
      flags_d[FLAG_Z] = bus_io.alu_flags_e[FLAG_Z];
    end
    if (commit && bus_io.flag_w_e[0]) begin
      flags_d[FLAG_C] = bus_io.alu_flags_e[FLAG_C];
      flags_d[FLAG_V] = bus_io.alu_flags_e[FLAG_V];
    end
  end

  // Architectural NZCV register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAG_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Gated controls; a stalled instruction still reports them, EX/MEM drops them
  always_comb begin
    bus_io.cond_ex_e      = cond_ex;
    bus_io.reg_write_g    = bus_io.reg_write_e & cond_ex & ~bus_io.no_write_e;
    bus_io.mem_write_g    = bus_io.mem_write_e & cond_ex;
    bus_io.pc_src_g       = bus_io.pc_src_e & cond_ex;
    bus_io.flags_q        = flags_q;
    bus_io.illegal_cond_e = bus_io.valid_e & (bus_io.cond_e == 4'b1111) & ~NV_ALWAYS;
  end

endmodule

// File: tb/tb_pipe_cond_unit.sv
// Directed bench for pipe_cond_unit: vector table plus condition sweep and reset cases.
module tb_pipe_cond_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipe_cond_unit_if bus ();

  pipe_cond_unit #(
    .FLAG_RST  (4'b0000),
    .NV_ALWAYS (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       stall;
    logic [3:0] cond;
    logic [1:0] fw;
    logic       nw;
    logic       rw;
    logic       mw;
    logic       pc;
    logic [3:0] alu;
    logic       x_cex;
    logic       x_rw;
    logic       x_mw;
    logic       x_pc;
    logic       x_ill;
    logic [3:0] x_flags;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic stall, input logic [3:0] cond,
                       input logic [1:0] fw, input logic nw, input logic rw, input logic mw,
                       input logic pc, input logic [3:0] alu);
    bus.valid_e     = valid;
    bus.stall_e     = stall;
    bus.cond_e      = cond;
    bus.flag_w_e    = fw;
    bus.no_write_e  = nw;
    bus.reg_write_e = rw;
    bus.mem_write_e = mw;
    bus.pc_src_e    = pc;
    bus.alu_flags_e = alu;
  endtask

  // Reference truth table written from the ARM condition definitions
  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z == 1'b1;
      4'd1:  return z == 1'b0;
      4'd2:  return c == 1'b1;
      4'd3:  return c == 1'b0;
      4'd4:  return n == 1'b1;
      4'd5:  return n == 1'b0;
      4'd6:  return v == 1'b1;
      4'd7:  return v == 1'b0;
      4'd8:  return (c == 1'b1) && (z == 1'b0);
      4'd9:  return (c == 1'b0) || (z == 1'b1);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return (z == 1'b0) && (n == v);
      4'd13: return (z == 1'b1) || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Load an arbitrary NZCV via an always-executed full flag write
  task automatic load_flags(input logic [3:0] f);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, f);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //                valid stall cond  fw     nw   rw   mw   pc   alu      cex  rw   mw   pc   ill  flags
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[3]  = '{1'b1, 1'b0, 4'h1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[4]  = '{1'b1, 1'b0, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011};
    vecs[5]  = '{1'b1, 1'b0, 4'hE, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011};
    vecs[6]  = '{1'b1, 1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011};
    vecs[7]  = '{1'b0, 1'b0, 4'hE, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011};
    vecs[8]  = '{1'b1, 1'b0, 4'hE, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
    vecs[9]  = '{1'b1, 1'b0, 4'h4, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[10] = '{1'b1, 1'b0, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110};
    vecs[11] = '{1'b1, 1'b0, 4'hC, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[12] = '{1'b1, 1'b0, 4'h9, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110};

    // Reset state, with an EQ instruction presented while in reset
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    #1;
    check("reset_flags", 32'(bus.flags_q), 32'h0);
    check("reset_eq_cex", 32'(bus.cond_ex_e), 32'h0);
    check("reset_eq_rwg", 32'(bus.reg_write_g), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'hE, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    rst_n = 1'b1;

    // Directed vector table: comb outputs mid-cycle, flags after the edge
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].stall, vecs[i].cond, vecs[i].fw, vecs[i].nw,
            vecs[i].rw, vecs[i].mw, vecs[i].pc, vecs[i].alu);
      #1;
      check($sformatf("v%0d_cex", i), 32'(bus.cond_ex_e), 32'(vecs[i].x_cex));
      check($sformatf("v%0d_rwg", i), 32'(bus.reg_write_g), 32'(vecs[i].x_rw));
      check($sformatf("v%0d_mwg", i), 32'(bus.mem_write_g), 32'(vecs[i].x_mw));
      check($sformatf("v%0d_pcg", i), 32'(bus.pc_src_g), 32'(vecs[i].x_pc));
      check($sformatf("v%0d_ill", i), 32'(bus.illegal_cond_e), 32'(vecs[i].x_ill));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_flags", i), 32'(bus.flags_q), 32'(vecs[i].x_flags));
    end

    // Full sweep: 16 NZCV x 16 conditions, with a mid-sweep asynchronous reset
    for (int f = 0; f < 16; f++) begin
      if (f == 8) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midsweep_async_rst", 32'(bus.flags_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      load_flags(4'(f));
      check($sformatf("sweep_load_%0d", f), 32'(bus.flags_q), 32'(f));
      @(negedge clk);
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, 1'b0, 4'(c), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        #1;
        check($sformatf("sweep_f%0d_c%0d", f, c), 32'(bus.cond_ex_e), 32'(ref_pass(4'(c), 4'(f))));
        if (c == 15) begin
          check($sformatf("sweep_ill_f%0d", f), 32'(bus.illegal_cond_e), 32'h1);
        end
      end
    end

    // Reset release: the first edge commits because its conditions hold
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
    #1;
    check("rst_hold_flags", 32'(bus.flags_q), 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_commit", 32'(bus.flags_q), 32'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
